// File: rtl/tpg_pkg.sv
// Test pattern generator types and the EBU colour-bar table.
package tpg_pkg;

  typedef enum logic [1:0] {
    ModeBars    = 2'd0,
    ModeRamp    = 2'd1,
    ModeChecker = 2'd2,
    ModeGrid    = 2'd3
  } tpg_mode_e;

  // R,G,B enable masks in bar order W,Y,C,G,M,R,B,K.
  localparam logic [2:0] EBU_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/video_types_pkg.sv
// Shared video datapath types used across the pixel pipeline.
package video_types_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_s;

endpackage

// File: rtl/test_pattern_gen.sv
// Per-pixel RGB test pattern source: colour bars, grey ramp, checkerboard or grid.
// Pattern controls are captured on newframe so a picture never changes mid-frame.
module test_pattern_gen
  import video_types_pkg::*;
  import tpg_pkg::*;
#(
  parameter int unsigned PIXELS_PER_LINE = 256,
  parameter int unsigned NUM_BARS        = 8,
  parameter int unsigned CELL_LOG2       = 5,
  parameter int unsigned LEVEL_FULL      = 255,
  parameter int unsigned LEVEL_REDUCED   = 191
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newframe,
  input  logic       newline,
  input  logic       newpixel,
  input  logic       visible_window,
  input  logic [1:0] mode,
  input  logic       reverse,
  input  logic       full_level,
  input  logic       scroll_en,
  output rgb_s       out,
  output logic       out_valid
);

  localparam int unsigned XW = $clog2(PIXELS_PER_LINE);
  localparam int unsigned BW = $clog2(NUM_BARS);
  localparam logic [7:0] LvlFull    = 8'(LEVEL_FULL);
  localparam logic [7:0] LvlReduced = 8'(LEVEL_REDUCED);

  // Extra MSB lets pixel_x park at PIXELS_PER_LINE once the line overruns.
  logic [XW:0]   pixel_x_q;
  logic [9:0]    line_y_q;
  logic [XW-1:0] scroll_off_q;
  tpg_mode_e     mode_q;
  logic          reverse_q;
  logic          full_level_q;
  logic          scroll_en_q;

  logic          accept;
  logic [7:0]    level;
  logic [XW-1:0] xs;
  logic [BW-1:0] bar_idx;
  logic [2:0]    idx8;
  logic [2:0]    mask;
  logic [7:0]    grey;
  logic [7:0]    ramp_v;
  logic          on;
  rgb_s          pix_d;

  assign accept = visible_window && newpixel && !newline;

  always_comb begin
    level   = full_level_q ? LvlFull : LvlReduced;
    xs      = pixel_x_q[XW-1:0] + scroll_off_q;
    bar_idx = BW'(xs >> (XW - BW));
    // Four bars pick every other EBU entry: W,C,M,B.
    idx8    = 3'(bar_idx) << (3 - BW);
    if (reverse_q) idx8 = ~idx8;
    mask    = EBU_RGB[idx8];
    grey    = 8'(pixel_x_q[XW-1:0] >> (XW - 8));
    ramp_v  = 8'((16'(grey) * 16'(level)) >> 8);
    on      = 1'b0;
    pix_d   = '0;
    case (mode_q)
      ModeBars: begin
        pix_d.r = mask[2] ? level : 8'd0;
        pix_d.g = mask[1] ? level : 8'd0;
        pix_d.b = mask[0] ? level : 8'd0;
      end
      ModeRamp: pix_d = '{r: ramp_v, g: ramp_v, b: ramp_v};
      ModeChecker: begin
        on    = pixel_x_q[CELL_LOG2] ^ line_y_q[CELL_LOG2];
        pix_d = on ? '{r: level, g: level, b: level} : '0;
      end
      ModeGrid: begin
        on    = (pixel_x_q[CELL_LOG2-1:0] == '0) || (line_y_q[CELL_LOG2-1:0] == '0);
        pix_d = on ? '{r: level, g: level, b: level} : '0;
      end
      default: pix_d = '0;
    endcase
    if (pixel_x_q[XW]) pix_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x_q    <= '0;
      line_y_q     <= '0;
      scroll_off_q <= '0;
      mode_q       <= ModeBars;
      reverse_q    <= 1'b0;
      full_level_q <= 1'b1;
      scroll_en_q  <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
    end else begin
      if (newframe) begin
        mode_q       <= tpg_mode_e'(mode);
        reverse_q    <= reverse;
        full_level_q <= full_level;
        scroll_en_q  <= scroll_en;
        scroll_off_q <= scroll_en ? scroll_off_q + 1'b1 : '0;
      end
      if (newframe) begin
        line_y_q <= '0;
      end else if (newline) begin
        line_y_q <= line_y_q + 1'b1;
      end
      if (newline) begin
        pixel_x_q <= '0;
      end else if (accept && !pixel_x_q[XW]) begin
        pixel_x_q <= pixel_x_q + 1'b1;
      end
      out_valid <= accept;
      if (accept) out <= pix_d;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomised scoreboard bench for test_pattern_gen against an arithmetic pattern model.
module tb_test_pattern_gen;
  import video_types_pkg::*;

  localparam int PPL  = 256;
  localparam int NB   = 8;
  localparam int CL   = 5;
  localparam int CELL = 1 << CL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       newframe = 1'b0;
  logic       newline = 1'b0;
  logic       newpixel = 1'b0;
  logic       visible_window = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       reverse = 1'b0;
  logic       full_level = 1'b1;
  logic       scroll_en = 1'b0;
  rgb_s       out;
  logic       out_valid;

  always #5 clk = ~clk;

  test_pattern_gen #(
    .PIXELS_PER_LINE(PPL),
    .NUM_BARS       (NB),
    .CELL_LOG2      (CL),
    .LEVEL_FULL     (255),
    .LEVEL_REDUCED  (191)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .newframe      (newframe),
    .newline       (newline),
    .newpixel      (newpixel),
    .visible_window(visible_window),
    .mode          (mode),
    .reverse       (reverse),
    .full_level    (full_level),
    .scroll_en     (scroll_en),
    .out           (out),
    .out_valid     (out_valid)
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_hold = 24'h0;
  logic        rst_at_edge = 1'b1;
  int          ebu[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  // Reference state: position, frame shadows and scroll offset.
  int m_x = 0, m_y = 0, m_off = 0, m_mode = 0;
  bit m_rev = 0, m_full = 1;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y, input int md,
                                            input bit rv, input bit fl, input int off);
    int lv, r, g, b, idx, gr;
    bit on;
    lv = fl ? 255 : 191;
    r = 0; g = 0; b = 0; on = 0;
    if (x >= PPL) return 24'h0;
    case (md)
      0: begin
        idx = ((x + off) % PPL) * NB / PPL;
        if (NB == 4) idx = idx * 2;
        if (rv) idx = 7 - idx;
        r = ((ebu[idx] >> 2) & 1) != 0 ? lv : 0;
        g = ((ebu[idx] >> 1) & 1) != 0 ? lv : 0;
        b = (ebu[idx] & 1) != 0 ? lv : 0;
      end
      1: begin
        gr = x * 256 / PPL;
        r = (gr * lv) / 256; g = r; b = r;
      end
      2: on = ((x / CELL) % 2) != ((y / CELL) % 2);
      default: on = (x % CELL == 0) || (y % CELL == 0);
    endcase
    if (md >= 2 && on) begin r = lv; g = lv; b = lv; end
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_valid", {23'b0, out_valid}, 24'h0);
      check("reset_out", out, 24'h0);
      exp_hold = 24'h0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %h expected no valid (t=%0t)", out, $time);
      end else begin
        exp_hold = exp_q.pop_front();
        check("pixel", out, exp_hold);
      end
    end else begin
      check("hold", out, exp_hold);
    end
  end

  task automatic tick(input bit nf, input bit nl, input bit np, input bit vw);
    if (vw && np && !nl) begin
      exp_q.push_back(model_pix(m_x, m_y, m_mode, m_rev, m_full, m_off));
      if (m_x < PPL) m_x++;
    end
    if (nl) begin
      m_x = 0;
      m_y = (m_y + 1) % 1024;
    end
    if (nf) begin
      m_y    = 0;
      m_mode = int'(mode);
      m_rev  = reverse;
      m_full = full_level;
      m_off  = scroll_en ? (m_off + 1) % PPL : 0;
    end
    newframe = nf; newline = nl; newpixel = np; visible_window = vw;
    @(posedge clk);
    #1;
    newframe = 0; newline = 0; newpixel = 0; visible_window = 0;
  endtask

  task automatic pixels(input int n, input bit rnd);
    int r;
    for (int i = 0; i < n; i++) begin
      r = rnd ? $urandom_range(0, 99) : 99;
      if (r < 10)      tick(0, 0, 0, 1);
      else if (r < 15) tick(0, 0, 1, 0);
      else if (r < 17) tick(0, 1, 1, 1);
      else             tick(0, 0, 1, 1);
    end
  endtask

  task automatic frame(input int lines, input int npix, input bit rnd);
    tick(1, 1, 0, 0);
    for (int l = 0; l < lines; l++) begin
      pixels(npix, rnd);
      tick(0, 1, 0, 0);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_x = 0; m_y = 0; m_off = 0; m_mode = 0; m_rev = 0; m_full = 1;
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-line, then one full line of default bars plus overrun pixels.
    mode = 2'd2;
    tick(0, 1, 0, 0);
    pixels(100, 0);
    tick(0, 0, 0, 0);
    do_reset(2);
    tick(0, 1, 0, 0);
    pixels(260, 0);

    // Reversed bars at reduced level.
    mode = 2'd0; reverse = 1; full_level = 0;
    frame(2, 256, 0);

    // Scrolling bars, including wrap of the offset past 255.
    reverse = 0; full_level = 1; scroll_en = 1;
    repeat (3) frame(1, 8, 0);
    frame(1, 256, 0);
    repeat (254) frame(1, 3, 0);

    // Live mode change mid-frame only takes effect at the next frame.
    scroll_en = 0; mode = 2'd1;
    tick(1, 1, 0, 0);
    pixels(256, 0);
    mode = 2'd2; full_level = 0;
    tick(0, 1, 0, 0);
    pixels(256, 0);
    frame(1, 256, 0);

    // Checkerboard and grid across cell boundaries.
    full_level = 1; mode = 2'd2;
    frame(66, 80, 0);
    mode = 2'd3;
    frame(66, 80, 0);

    // Collision and invisible strobes.
    tick(0, 1, 1, 1);
    tick(0, 0, 1, 0);
    pixels(4, 0);
    tick(0, 0, 1, 0);
    tick(0, 1, 1, 1);

    // Random frames with random controls and strobe patterns.
    for (int f = 0; f < 8; f++) begin
      mode       = 2'($urandom_range(0, 3));
      reverse    = 1'($urandom_range(0, 1));
      full_level = 1'($urandom_range(0, 1));
      scroll_en  = 1'($urandom_range(0, 1));
      frame($urandom_range(3, 5), 300, 1);
    end

    repeat (3) tick(0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pixels: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
